// File: rtl/pipe_stage_reg.sv
// Falling-edge pipeline stage register with valid/ready handshake, flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers the in_ready path.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic              in_xfer;
    logic              main_free;

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign in_xfer   = in_valid && in_ready;
    assign main_free = !valid_q || out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Registered ready: upstream never sees a combinational path from out_ready.
    assign in_ready = !skid_valid;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            data_q     <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low here, so no input transfer can coincide.
            if (main_free) begin
                valid_q    <= 1'b1;
                ctrl_q     <= skid_ctrl;
                data_q     <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!main_free) begin
            if (in_xfer) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
            end
        end else begin
            valid_q <= in_xfer;
            ctrl_q  <= in_xfer ? in_ctrl : '0;
            if (in_xfer) begin
                data_q <= in_data;
            end
        end
    end
`else
    assign in_ready = main_free;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (main_free) begin
            valid_q <= in_valid;
            ctrl_q  <= in_valid ? in_ctrl : '0;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end
`endif

    // Counts every stalled edge, flush or not; only reset clears it.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (valid_q && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (CNT_W=4 so saturation is reachable quickly).
// Expectations branch on PIPE_STAGE_SKID_EN where base and skid behaviour differ.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 6;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance through one active (falling) edge and settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming: each value appears one edge after it is presented.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h11 + 64'(i);
            in_ctrl  = 6'(i + 1);
            step();
            check("stream_data", out_data, 64'h11 + 64'(i));
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_ctrl", 64'(out_ctrl), 64'(i + 1));
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", 64'(out_valid), 64'd0);
        check("stream_drain_ctrl", 64'(out_ctrl), 64'd0);
        check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

        // Backpressure for 5 edges with a second item waiting upstream.
        in_valid = 1'b1;
        in_data  = 64'h21;
        in_ctrl  = 6'd5;
        step();
        check("bp_load_data", out_data, 64'h21);
        out_ready = 1'b0;
        in_data   = 64'h22;
        in_ctrl   = 6'd6;
        for (int i = 0; i < 5; i++) begin
            #1;
`ifdef PIPE_STAGE_SKID_EN
            check("bp_in_ready", 64'(in_ready), (i == 0) ? 64'd1 : 64'd0);
`else
            check("bp_in_ready", 64'(in_ready), 64'd0);
`endif
            step();
            check("bp_hold_data", out_data, 64'h21);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        check("bp_stall_cnt", 64'(stall_cnt), 64'd5);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
`ifdef PIPE_STAGE_SKID_EN
        check("bp_skid_release_valid", 64'(out_valid), 64'd1);
        check("bp_skid_release_data", out_data, 64'h22);
        check("bp_skid_release_ctrl", 64'(out_ctrl), 64'd6);
        step();
`endif
        check("bp_empty_valid", 64'(out_valid), 64'd0);
        check("bp_empty_ctrl", 64'(out_ctrl), 64'd0);
        check("bp_stall_after", 64'(stall_cnt), 64'd5);

        // Flush beats a simultaneous input transfer; stall still counted.
        in_valid = 1'b1;
        in_data  = 64'h31;
        in_ctrl  = 6'd2;
        step();
        flush     = 1'b1;
        in_ctrl   = 6'h3F;
        in_data   = 64'h32;
        out_ready = 1'b0;
        step();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'd0);
        check("flush_data_hold", out_data, 64'h31);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_stall_cnt", 64'(stall_cnt), 64'd6);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_after_valid", 64'(out_valid), 64'd0);

        // Replace-on-full: simultaneous output and input transfer.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h41;
        in_ctrl   = 6'd1;
        step();
        check("rof_first_data", out_data, 64'h41);
        in_data = 64'hAB;
        in_ctrl = 6'd7;
        #1;
        check("rof_in_ready", 64'(in_ready), 64'd1);
        step();
        check("rof_data", out_data, 64'hAB);
        check("rof_valid", 64'(out_valid), 64'd1);
        check("rof_ctrl", 64'(out_ctrl), 64'd7);

        // Saturation: stall_cnt starts at 6 and must clamp at 15.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 8)  check("sat_k8", 64'(stall_cnt), 64'd14);
            if (k == 9)  check("sat_k9", 64'(stall_cnt), 64'd15);
            if (k == 20) check("sat_k20", 64'(stall_cnt), 64'd15);
        end
        check("sat_valid_hold", 64'(out_valid), 64'd1);

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ctrl", 64'(out_ctrl), 64'd0);
        check("arst_data", out_data, 64'd0);
        check("arst_stall", 64'(stall_cnt), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        #3 rst_n = 1'b1;
        step();
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_ctrl", 64'(out_ctrl), 64'd0);
        check("post_rst_stall", 64'(stall_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
